// File: rtl/softmax_norm_pkg.sv
// Shared types for the softmax normaliser: FSM state encoding and accumulator sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package softmax_norm_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_DIV  = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   // Accumulator width that cannot wrap when n_max elements of data_w bits are summed.
   function automatic int sum_width(input int data_w, input int n_max);
      return data_w + $clog2(n_max);
   endfunction

endpackage

// File: rtl/softmax_norm_unit_div.sv
// Restoring divider producing the low Q_W quotient bits of num/den, saturating when
// the quotient would need more bits. Latency: start cycle + Q_W iterations (done is
// combinational in the final iteration). Backpressure: none; start is ignored while busy.
// Ports: start loads num/den; busy marks iterations; done/quot are valid together.
module seq_div_unsigned #(
   parameter int NUM_W = 35,
   parameter int DEN_W = 19,
   parameter int Q_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [Q_W-1:0]   quot
);

   localparam int CNT_W = $clog2(Q_W + 1);

   logic [DEN_W-1:0] rem_q;
   logic [Q_W-1:0]   lo_q;      // remaining low numerator bits, MSB first
   logic [Q_W-2:0]   q_q;       // quotient bits produced so far
   logic             sat_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;

   logic [DEN_W:0]   trial_sh;
   logic             q_bit;
   logic [DEN_W-1:0] rem_n;
   logic [Q_W-1:0]   q_shift;

   always_comb begin
      trial_sh = {rem_q, lo_q[Q_W-1]};
      q_bit    = (trial_sh >= {1'b0, den});
      rem_n    = q_bit ? DEN_W'(trial_sh - {1'b0, den}) : trial_sh[DEN_W-1:0];
      q_shift  = {q_q, q_bit};
   end

   assign busy = run_q;
   assign done = run_q && (cnt_q == CNT_W'(1));
   // Upper numerator part already >= den means the quotient does not fit in Q_W bits.
   assign quot = sat_q ? {Q_W{1'b1}} : q_shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         lo_q  <= '0;
         q_q   <= '0;
         sat_q <= 1'b0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start && !run_q) begin
         rem_q <= num[NUM_W-1:Q_W];
         lo_q  <= num[Q_W-1:0];
         q_q   <= '0;
         sat_q <= (num[NUM_W-1:Q_W] >= den);
         cnt_q <= CNT_W'(Q_W);
         run_q <= 1'b1;
      end else if (run_q) begin
         rem_q <= rem_n;
         lo_q  <= {lo_q[Q_W-2:0], 1'b0};
         q_q   <= q_shift[Q_W-2:0];
         cnt_q <= cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/softmax_norm_unit.sv
// Streaming sum-normaliser: buffers up to N_MAX activations, then emits each as a Q0.OUT_W fraction of the sum.
// Latency: OUT_W+2 cycles from the last input beat to the first output; one element per OUT_W+2 cycles.
// Backpressure: in_ready only in LOAD; output beat held stable until out_ready.
// Ports: in_* input stream, out_* output stream, zero_sum/overflow status, busy.
// Optional: SOFTMAX_NORM_ARGMAX_EN adds argmax (index of largest element, valid with out_last).
module softmax_norm_unit
   import softmax_norm_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int N_MAX  = 8,
   parameter int OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              zero_sum,
   output logic              overflow,
   output logic              busy
`ifdef SOFTMAX_NORM_ARGMAX_EN
   ,
   output logic [$clog2(N_MAX)-1:0] argmax
`endif
);

   localparam int SUM_W = sum_width(DATA_W, N_MAX);
   localparam int IDX_W = $clog2(N_MAX);
   localparam int CNT_W = $clog2(N_MAX + 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] elem_buf [N_MAX];
   logic [CNT_W-1:0]  count_q;
   logic [SUM_W-1:0]  sum_q;
   logic [IDX_W-1:0]  idx_q;

   logic              last_slot, load_done, sum_zero, elem_last;
   logic              div_start, div_busy, div_done;
   logic [OUT_W-1:0]  div_quot;

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_EMIT);
   assign busy      = !((state_q == ST_LOAD) && (count_q == '0));

   assign last_slot = (count_q == CNT_W'(N_MAX - 1));
   assign load_done = in_valid && (in_last || last_slot);
   assign sum_zero  = (sum_q == '0);
   assign elem_last = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
   // Zero-sum vectors bypass the divider entirely.
   assign div_start = (state_q == ST_DIV) && !div_busy && !sum_zero;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (load_done) state_d = ST_DIV;
         ST_DIV:  if (sum_zero || div_done) state_d = ST_EMIT;
         ST_EMIT: if (out_ready) state_d = out_last ? ST_LOAD : ST_DIV;
         default: state_d = ST_LOAD;
      endcase
   end

   // Element buffer carries no reset: it is only read after being written in LOAD.
   always_ff @(posedge clk) begin
      if ((state_q == ST_LOAD) && in_valid)
         elem_buf[count_q[IDX_W-1:0]] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         sum_q    <= '0;
         idx_q    <= '0;
         out_data <= '0;
         out_last <= 1'b0;
         zero_sum <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (in_valid) begin
                  sum_q   <= sum_q + SUM_W'(in_data);
                  count_q <= count_q + CNT_W'(1);
                  idx_q   <= '0;
                  if (count_q == '0) begin
                     zero_sum <= 1'b0;
                     overflow <= 1'b0;
                  end
                  // Buffer full without in_last: force-terminate; the next beat opens a new vector.
                  if (last_slot && !in_last) overflow <= 1'b1;
               end
            end
            ST_DIV: begin
               if (sum_zero) begin
                  out_data <= '0;
                  out_last <= elem_last;
                  zero_sum <= 1'b1;
               end else if (div_done) begin
                  out_data <= div_quot;
                  out_last <= elem_last;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     count_q <= '0;
                     sum_q   <= '0;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SOFTMAX_NORM_ARGMAX_EN
   logic [DATA_W-1:0] max_q;

   // Strict greater-than keeps the lowest index on ties.
   always_ff @(posedge clk) begin
      if (rst) begin
         argmax <= '0;
         max_q  <= '0;
      end else if ((state_q == ST_LOAD) && in_valid) begin
         if ((count_q == '0) || (in_data > max_q)) begin
            max_q  <= in_data;
            argmax <= count_q[IDX_W-1:0];
         end
      end
   end
`endif

   seq_div_unsigned #(
      .NUM_W (SUM_W + OUT_W),
      .DEN_W (SUM_W),
      .Q_W   (OUT_W)
   ) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .num   ({SUM_W'(elem_buf[idx_q]), {OUT_W{1'b0}}}),
      .den   (sum_q),
      .busy  (div_busy),
      .done  (div_done),
      .quot  (div_quot)
   );

endmodule

// File: tb/tb_softmax_norm_unit.sv
`timescale 1ns/1ps
module tb_softmax_norm_unit;

   localparam int DATA_W    = 16;
   localparam int N_MAX     = 8;
   localparam int OUT_W     = 16;
   localparam int DIV_EDGES = OUT_W + 1;   // clock edges from a handshake to out_valid (sum != 0)
   localparam int WAIT_MAX  = 100;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, in_last;
   logic              out_valid, out_ready, out_last, zero_sum, overflow, busy;
   logic [DATA_W-1:0] in_data;
   logic [OUT_W-1:0]  out_data;
`ifdef SOFTMAX_NORM_ARGMAX_EN
   logic [$clog2(N_MAX)-1:0] argmax;
`endif

   int checks = 0;
   int errors = 0;

   int vec[$];
   bit vec_last;
   int stall_elem;
   int stall_cyc;
   bit junk;

   always #5 clk = ~clk;

   softmax_norm_unit #(.DATA_W(DATA_W), .N_MAX(N_MAX), .OUT_W(OUT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .zero_sum  (zero_sum),
      .overflow  (overflow),
      .busy      (busy)
`ifdef SOFTMAX_NORM_ARGMAX_EN
      ,
      .argmax    (argmax)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: element / sum as a Q0.OUT_W fraction, clipped to the largest code.
   function automatic longint ref_frac(input longint e, input longint s);
      longint q;
      if (s == 0) return 0;
      q = (e << OUT_W) / s;
      if (q > (longint'(1) << OUT_W) - 1) q = (longint'(1) << OUT_W) - 1;
      return q;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_reset_state(input string name);
      check({name, ".in_ready"},  in_ready, 1);
      check({name, ".out_valid"}, out_valid, 0);
      check({name, ".out_data"},  out_data, 0);
      check({name, ".out_last"},  out_last, 0);
      check({name, ".zero_sum"},  zero_sum, 0);
      check({name, ".overflow"},  overflow, 0);
      check({name, ".busy"},      busy, 0);
   endtask

   task automatic send_vec(input string name);
      for (int i = 0; i < vec.size(); i++) begin
         in_valid = 1'b1;
         in_data  = DATA_W'(vec[i]);
         in_last  = vec_last && (i == vec.size() - 1);
         check($sformatf("%s.in_ready[%0d]", name, i), in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect_vec(input string name);
      longint s = 0;
      int     amax = 0;
      int     n = vec.size();
      bit     ovf = !vec_last && (n == N_MAX);
      int     cyc;
      longint exp_d;
      for (int i = 0; i < n; i++) begin
         s += vec[i];
         if (vec[i] > vec[amax]) amax = i;
      end
      for (int k = 0; k < n; k++) begin
         exp_d = ref_frac(vec[k], s);
         if (junk) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
         end
         if (k == stall_elem) out_ready = 1'b0;
         cyc = 0;
         while (out_valid !== 1'b1 && cyc < WAIT_MAX) begin
            check($sformatf("%s.in_ready_div[%0d]", name, k), in_ready, 0);
            tick();
            cyc++;
         end
         check($sformatf("%s.latency[%0d]", name, k), cyc, (s == 0) ? 1 : DIV_EDGES);
         check($sformatf("%s.data[%0d]", name, k), out_data, exp_d);
         check($sformatf("%s.last[%0d]", name, k), out_last, (k == n - 1));
         check($sformatf("%s.zero_sum[%0d]", name, k), zero_sum, (s == 0));
         check($sformatf("%s.overflow[%0d]", name, k), overflow, ovf);
`ifdef SOFTMAX_NORM_ARGMAX_EN
         if (k == n - 1) check($sformatf("%s.argmax", name), argmax, amax);
`endif
         if (k == stall_elem) begin
            for (int c = 0; c < stall_cyc; c++) begin
               tick();
               check($sformatf("%s.stall_valid[%0d]", name, c), out_valid, 1);
               check($sformatf("%s.stall_data[%0d]", name, c), out_data, exp_d);
               check($sformatf("%s.stall_in_ready[%0d]", name, c), in_ready, 0);
            end
            out_ready = 1'b1;
         end
         if (k == n - 1) in_valid = 1'b0;   // nothing may be taken once LOAD reopens
         tick();
      end
      in_valid = 1'b0;
      check({name, ".idle_busy"},     busy, 0);
      check({name, ".idle_in_ready"}, in_ready, 1);
      check({name, ".idle_valid"},    out_valid, 0);
      check({name, ".hold_zero_sum"}, zero_sum, (s == 0));
      check({name, ".hold_overflow"}, overflow, ovf);
   endtask

   task automatic run_vec(input string name);
      send_vec(name);
      collect_vec(name);
      stall_elem = -1;
      junk       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      vec_last = 1'b1; stall_elem = -1; stall_cyc = 0; junk = 1'b0;
      tick(); tick();
      check_reset_state("reset");
      rst = 1'b0;

      vec = '{1, 1, 2};          run_vec("v112");
      vec = '{100};              run_vec("single");
      vec = '{0, 0, 0};          run_vec("zeros");

      // Eight beats without in_last: truncated at N_MAX; the ninth beat opens a new vector.
      vec = '{1, 1, 1, 1, 1, 1, 1, 1}; vec_last = 1'b0; run_vec("trunc");
      vec = '{1};                      vec_last = 1'b1; run_vec("ninth");

      vec = '{3, 1}; stall_elem = 0; stall_cyc = 5; run_vec("stall");

      // Reset four cycles into DIV discards the vector.
      vec = '{5, 5};
      send_vec("rst_mid");
      repeat (4) tick();
      check("rst_mid.busy_before", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("rst_mid");
      for (int c = 0; c < 2 * DIV_EDGES; c++) begin
         check("rst_mid.no_output", out_valid, 0);
         tick();
      end
      vec = '{2, 2};             run_vec("after_rst");

      vec = '{4, 9, 9, 1};       run_vec("argmax");

      for (int t = 0; t < 10; t++) begin
         int n    = $urandom_range(1, N_MAX);
         int mode = $urandom_range(0, 3);
         vec.delete();
         for (int i = 0; i < n; i++) begin
            case (mode)
               1:       vec.push_back($urandom_range(0, 3));
               2:       vec.push_back(0);
               default: vec.push_back($urandom_range(0, (1 << DATA_W) - 1));
            endcase
         end
         vec_last   = !((n == N_MAX) && ($urandom_range(0, 1) == 1));
         junk       = ($urandom_range(0, 1) == 1);
         stall_elem = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
         stall_cyc  = $urandom_range(1, 4);
         run_vec($sformatf("rand%0d", t));
         vec_last = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
